// File: rtl/pipeline_trace_buffer.sv
// Write-back trace capture buffer for the 5-stage pipeline.
// Records retired {instr, pc, result} into a circular buffer once armed,
// triggers on a selectable pipeline event, captures a post-trigger window,
// then freezes and streams the trace oldest-first over a valid/ready port.
module pipeline_trace_buffer #(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wb_valid,
  input  logic [XLEN-1:0]  wb_instr,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic [XLEN-1:0]  wb_result,
  input  logic             branch_taken,
  input  logic             jump_taken,
  input  logic             arm,
  input  logic             clear,
  input  logic [1:0]       trig_mode,
  input  logic [XLEN-1:0]  trig_match,
  input  logic             trig_force,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [XLEN-1:0]  rd_instr,
  output logic [XLEN-1:0]  rd_pc,
  output logic [XLEN-1:0]  rd_result,
  output logic             rd_last,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] entry_count,
  output logic             wrapped
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           cur_state;
  state_t           next_state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] post_cnt;
  logic             trig_hit;
  logic             capture;
  logic             full;
  logic             pop;

  logic [XLEN-1:0] mem_instr  [DEPTH];
  logic [XLEN-1:0] mem_pc     [DEPTH];
  logic [XLEN-1:0] mem_result [DEPTH];

  // Trigger decode, capture/pop qualifiers, next-state and next pointer values
  always_comb begin
    trig_hit    = trig_force
                | ((trig_mode == 2'd1) & wb_valid & (wb_instr == trig_match))
                | ((trig_mode == 2'd2) & branch_taken)
                | ((trig_mode == 2'd3) & jump_taken);
    capture     = wb_valid & ((cur_state == ARMED) | (cur_state == POST));
    full        = (entry_count == CNT_W'(DEPTH));
    pop         = rd_valid & rd_ready;
    wr_ptr_next = capture ? PTR_W'(wr_ptr + 1'b1) : wr_ptr;
    count_next  = (capture && !full) ? CNT_W'(entry_count + 1'b1) : entry_count;
    next_state  = cur_state;
    case (cur_state)
      IDLE:  if (arm) next_state = ARMED;
      ARMED: if (trig_hit) next_state = (POST_TRIG == 0) ? DONE : POST;
      POST:  if (wb_valid && post_cnt == CNT_W'(1)) next_state = DONE;
      DONE:  if (entry_count == '0 || (pop && rd_last)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // clear overrides everything, including a coincident arm
    if (clear) next_state = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= IDLE;
    else        cur_state <= next_state;
  end

  // Pointers, entry counter, post-trigger counter and wrap flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entry_count <= '0;
      post_cnt    <= '0;
      wrapped     <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      entry_count <= '0;
      post_cnt    <= '0;
      wrapped     <= 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          if (arm) begin
            wr_ptr      <= '0;
            entry_count <= '0;
            post_cnt    <= '0;
            wrapped     <= 1'b0;
          end
        end
        ARMED, POST: begin
          wr_ptr      <= wr_ptr_next;
          entry_count <= count_next;
          if (capture && full) wrapped <= 1'b1;
          if (cur_state == ARMED && trig_hit) post_cnt <= CNT_W'(POST_TRIG);
          if (cur_state == POST && wb_valid)  post_cnt <= CNT_W'(post_cnt - 1'b1);
          // Oldest surviving entry sits entry_count slots behind the write pointer
          if (next_state == DONE) rd_ptr <= PTR_W'(wr_ptr_next - count_next[PTR_W-1:0]);
        end
        DONE: begin
          if (pop) begin
            rd_ptr      <= PTR_W'(rd_ptr + 1'b1);
            entry_count <= CNT_W'(entry_count - 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

  // Trace storage; contents are don't-care after reset so no reset here
  always_ff @(posedge clk) begin
    if (capture && !clear) begin
      mem_instr[wr_ptr]  <= wb_instr;
      mem_pc[wr_ptr]     <= wb_pc;
      mem_result[wr_ptr] <= wb_result;
    end
  end

  assign state     = cur_state;
  assign rd_valid  = (cur_state == DONE) && (entry_count != '0);
  assign rd_last   = (cur_state == DONE) && (entry_count == CNT_W'(1));
  assign rd_instr  = mem_instr[rd_ptr];
  assign rd_pc     = mem_pc[rd_ptr];
  assign rd_result = mem_result[rd_ptr];

endmodule

// File: doc/pipeline_trace_buffer.md
Name: pipeline_trace_buffer

Overview:
Parametrised write-back trace capture for the 5-stage pipeline datapath. It replaces free-running $monitor-style stage probing with an on-chip circular buffer. The buffer records retired instructions (instr, PC, result), arms under software control, triggers on a selectable pipeline event, and captures a programmable post-trigger window. The frozen trace is then streamed out oldest-first over a valid/ready port. It sits beside the datapath, fed from the WB stage plus MEM-stage branch/jump flags.

Parameters:
XLEN, 32, width of instr/PC/result fields
DEPTH, 16, trace entries; power of two, >=2
POST_TRIG, 8, valid entries captured after the trigger entry; 0..DEPTH-1
CNT_W, $clog2(DEPTH+1), width of entry_count

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
wb_valid  in  1  an instruction retires this cycle
wb_instr  in  XLEN  retiring instruction word
wb_pc  in  XLEN  retiring PC
wb_result  in  XLEN  retiring ALU/write-back value
branch_taken  in  1  MEM-stage taken branch (Branch_mem & ifbranch)
jump_taken  in  1  MEM-stage jump (Jump_mem)
arm  in  1  pulse: start capture
clear  in  1  synchronous abort to IDLE
trig_mode  in  2  0=force only, 1=instr match, 2=branch taken, 3=jump
trig_match  in  XLEN  instruction value compared in mode 1
trig_force  in  1  immediate trigger in any mode
rd_valid  out  1  trace entry available
rd_ready  in  1  consumer accepts entry
rd_instr  out  XLEN  entry instruction
rd_pc  out  XLEN  entry PC
rd_result  out  XLEN  entry result
rd_last  out  1  current entry is the final one
state  out  2  0=IDLE,1=ARMED,2=POST,3=DONE
entry_count  out  CNT_W  valid entries held
wrapped  out  1  sticky: oldest entries overwritten since arm

Behaviour:
- Reset (async) and clear (sync, highest priority): state=IDLE, wr_ptr=0, rd_ptr=0, entry_count=0, post counter=0, wrapped=0. rd_valid=0 and rd_last=0. Buffer contents are don't-care.
- IDLE: arm=1 -> ARMED next cycle. Nothing is captured in the arm cycle. wrapped is cleared on arm.
- ARMED and POST capture rule: wb_valid=1 writes {instr,pc,result} at wr_ptr on the same edge. wr_ptr increments mod DEPTH. entry_count increments and saturates at DEPTH. A write while entry_count==DEPTH overwrites the oldest entry and sets wrapped.
- Trigger event (ARMED only): trig_force, or mode1 wb_valid & (wb_instr==trig_match), or mode2 branch_taken, or mode3 jump_taken.
- Trigger response:
  - The trigger-cycle entry is written iff wb_valid=1.
  - POST_TRIG==0 -> DONE next cycle.
  - Otherwise -> POST with post counter=POST_TRIG.
  - Triggers in POST/DONE are ignored.
- POST: each wb_valid write decrements the post counter. The write that takes it to 0 moves state to DONE on the same edge.
- DONE: capture is frozen and wb_* are ignored.
  - rd_ptr = (wr_ptr - entry_count) mod DEPTH, latched on entry.
  - rd_valid = (entry_count!=0).
  - rd_* is a combinational read at rd_ptr.
  - rd_last = (entry_count==1).
  - Handshake: rd_valid & rd_ready pops: rd_ptr++ mod DEPTH, entry_count--. rd_* must hold stable while rd_valid & !rd_ready.
  - The pop with rd_last=1 -> IDLE next cycle.
  - DONE entered with entry_count==0 -> IDLE next cycle, rd_valid never asserted.
- arm is ignored outside IDLE.
- clear and arm in the same cycle: clear wins, state=IDLE.
- Async reset mid-capture or mid-readout: immediate IDLE. No partial entry survives.
- Latency: capture is visible in entry_count one cycle after the wb_valid edge. The first rd_valid is the cycle after the DONE transition.

Test Plan:
1. DEPTH=8, POST_TRIG=3, mode1. Arm, then retire k=0..19 with pc=4k and instr=0x100+k; trig_match=0x10A. Required: DONE after k=13; entry_count=8; wrapped=1; readout with rd_ready=1 yields pc 0x18,0x1C,...,0x34 in order; rd_last only on pc=0x34; state=IDLE the cycle after.
2. Mode2, POST_TRIG=0. Arm, retire 3 instrs, then pulse branch_taken with wb_valid=0. Required: DONE with entry_count=3, wrapped=0; 3 entries read oldest-first.
3. Readout backpressure: in DONE, toggle rd_ready 1,0,0,1. Required: rd_pc stable during both stalled cycles; exactly 2 pops; entry_count drops by 2.
4. trig_force right after arm with no wb_valid. Required: DONE for 1 cycle with rd_valid=0, then IDLE, entry_count=0.
5. Assert clear in POST (and separately rst_n=0 mid-readout). Required: IDLE, entry_count=0, rd_valid=0 on the next edge (immediately for rst_n); a new arm recaptures from scratch.
6. Mode3 with arm and clear asserted in the same cycle, then jump_taken. Required: state stays IDLE and no trigger is taken.
